// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one radix-2 step per cycle.
// Valid/ready request and held result, with flush to kill an in-flight op.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
    localparam logic [CW-1:0] ONE = CW'(1);
    localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ONES = '1;

    state_t state, state_nx;

    logic [CW-1:0]     cnt;
    logic [2:0]        op_q;
    logic              a_neg_q, b_neg_q;
    logic [XLEN-1:0]   mb_q;
    logic [2*XLEN-1:0] acc;

    logic              a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              b_zero, ovf, special, accept;
    logic [XLEN-1:0]   special_res;

    logic [XLEN:0]     msum, shl;
    logic              ge;
    logic [XLEN-1:0]   rsub, quo, rem, fix_res;
    logic [2*XLEN-1:0] step, prod;

    always_comb begin
        a_sgn = op[2] ? ~op[0] : (op[1:0] != 2'b11);
        b_sgn = op[2] ? ~op[0] : ~op[1];
        a_neg = a_sgn & a[XLEN-1];
        b_neg = b_sgn & b[XLEN-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
        b_zero = (b == '0);
        ovf = ~op[0] & (a == MIN) & (b == ONES);
        special = op[2] & (b_zero | ovf);
        unique case (1'b1)
            b_zero & ~op[1]:  special_res = ONES;
            b_zero & op[1]:   special_res = a;
            ~b_zero & op[1]:  special_res = '0;
            default:          special_res = MIN;
        endcase
    end

    assign accept = in_valid & in_ready & ~flush;

    // acc doubles as the product register or as {remainder, quotient}
    always_comb begin
        msum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mb_q} : '0);
        shl = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        ge = (shl >= {1'b0, mb_q});
        rsub = shl[XLEN-1:0] - mb_q;
        if (op_q[2])
            step = {(ge ? rsub : shl[XLEN-1:0]), acc[XLEN-2:0], ge};
        else
            step = {msum, acc[XLEN-1:1]};
        prod = (a_neg_q ^ b_neg_q) ? -acc : acc;
        quo = acc[XLEN-1:0];
        rem = acc[2*XLEN-1:XLEN];
        unique case (1'b1)
            ~op_q[2] & (op_q[1:0] == 2'b00): fix_res = prod[XLEN-1:0];
            ~op_q[2] & (op_q[1:0] != 2'b00): fix_res = prod[2*XLEN-1:XLEN];
            op_q[2] & ~op_q[1]: fix_res = (a_neg_q ^ b_neg_q) ? -quo : quo;
            default:            fix_res = a_neg_q ? -rem : rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE: if (accept) state_nx = special ? DONE : CALC;
                CALC: if (cnt == LAST) state_nx = FIX;
                FIX:  state_nx = DONE;
                DONE: if (out_ready) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready = (state == IDLE);
        busy = (state != IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            op_q <= '0;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            mb_q <= '0;
            acc <= '0;
            result <= '0;
        end else if (flush) begin
            cnt <= '0;
            result <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        op_q <= op;
                        a_neg_q <= a_neg;
                        b_neg_q <= b_neg;
                        mb_q <= b_mag;
                        acc <= {{XLEN{1'b0}}, a_mag};
                        cnt <= '0;
                        if (special) result <= special_res;
                    end
                end
                CALC: begin
                    acc <= step;
                    cnt <= cnt + ONE;
                end
                FIX: result <= fix_res;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus randomized ops
// compared every cycle against an arithmetic reference model.
module tb_muldiv_unit;

    localparam int XLEN = 32;
    localparam logic [31:0] MIN = 32'h8000_0000;
    localparam logic [31:0] ONES = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        busy;

    int n_chk = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;

    bit          pend = 1'b0;
    int          age = 0;
    int          lat = 0;
    logic [31:0] exp_r = '0;
    logic [31:0] res_exp = '0;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] o,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint ux = longint'({32'b0, x});
        longint uy = longint'({32'b0, y});
        logic [63:0] p;
        p = '0;
        case (o)
            3'd0: begin p = sx * sy; return p[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * uy; return p[63:32]; end
            3'd3: begin p = ux * uy; return p[63:32]; end
            3'd4: begin
                if (y == 0) return ONES;
                if (x == MIN && y == ONES) return MIN;
                p = sx / sy; return p[31:0];
            end
            3'd5: begin
                if (y == 0) return ONES;
                p = ux / uy; return p[31:0];
            end
            3'd6: begin
                if (y == 0) return x;
                p = sx % sy; return p[31:0];
            end
            default: begin
                if (y == 0) return x;
                p = ux % uy; return p[31:0];
            end
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] o,
                                      input logic [31:0] x,
                                      input logic [31:0] y);
        return o[2] && (y == 0 || (!o[0] && x == MIN && y == ONES));
    endfunction

    // Reference timeline: IDLE until a request, then ready after lat edges
    always @(posedge clk) begin
        if (rst || flush) begin
            pend = 1'b0;
            res_exp = '0;
        end else if (!pend) begin
            if (in_valid) begin
                pend = 1'b1;
                age = 0;
                exp_r = model(op, a, b);
                lat = is_special(op, a, b) ? 0 : XLEN + 1;
                if (lat == 0) res_exp = exp_r;
            end
        end else if (age >= lat) begin
            if (out_ready) pend = 1'b0;
        end else begin
            age++;
            if (age == lat) res_exp = exp_r;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("out_valid", out_valid, pend && age >= lat);
            chk("in_ready", in_ready, !pend);
            chk("busy", busy, pend);
            chk("result", result, res_exp);
            chk("valid_ready_excl", out_valid & in_ready, 1'b0);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y);
        op = o; a = x; b = y; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int exp_n, input string nm);
        int n = 0;
        while (!out_valid && n < 200) begin
            tick();
            n++;
        end
        chk({nm, "_latency"}, n, exp_n);
    endtask

    task automatic take;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic run(input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] lit,
                       input string nm);
        issue(o, x, y);
        wait_valid(is_special(o, x, y) ? 0 : XLEN + 1, nm);
        chk(nm, result, lit);
        take();
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return ONES;
            2: return MIN;
            3: return 32'($urandom_range(1, 9));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int seen;
        logic [2:0] o;
        logic [31:0] x, y;

        chk("model_mul", model(3'd0, 32'd7, -32'sd3), 32'hFFFF_FFEB);
        chk("model_mulhsu", model(3'd2, MIN, ONES), 32'h8000_0000);
        chk("model_div", model(3'd4, -32'sd7, 32'd2), 32'hFFFF_FFFD);
        chk("model_rem", model(3'd6, -32'sd7, 32'd2), 32'hFFFF_FFFF);

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_result", result, 32'h0);
        chk("rst_busy", busy, 1'b0);
        mon_en = 1'b1;

        run(3'd0, 32'd7, -32'sd3, 32'hFFFF_FFEB, "mul_7_m3");

        run(3'd1, MIN, ONES, 32'h0000_0000, "mulh");
        run(3'd3, MIN, ONES, 32'h7FFF_FFFF, "mulhu");
        run(3'd2, MIN, ONES, 32'h8000_0000, "mulhsu");
        run(3'd0, MIN, ONES, 32'h8000_0000, "mul_min");

        run(3'd4, -32'sd7, 32'd2, 32'hFFFF_FFFD, "div_m7_2");
        run(3'd6, -32'sd7, 32'd2, 32'hFFFF_FFFF, "rem_m7_2");
        run(3'd5, -32'sd7, 32'd2, 32'h7FFF_FFFC, "divu_m7_2");
        run(3'd7, -32'sd7, 32'd2, 32'h0000_0001, "remu_m7_2");

        run(3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, "div_by0");
        run(3'd7, 32'd5, 32'd0, 32'h0000_0005, "remu_by0");
        run(3'd4, MIN, ONES, 32'h8000_0000, "div_ovf");
        run(3'd6, MIN, ONES, 32'h0000_0000, "rem_ovf");

        issue(3'd0, 32'd3, 32'd4);
        wait_valid(XLEN + 1, "bp_mul");
        chk("bp_mul", result, 32'd12);
        op = 3'd3; a = ONES; b = ONES; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_result", result, 32'd12);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_not_taken_early", busy, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("bp_accept_next", busy, 1'b1);
        wait_valid(XLEN + 1, "bp_mulhu");
        chk("bp_mulhu", result, 32'hFFFF_FFFE);
        take();

        for (int k = 0; k < 2; k++) begin
            issue(3'd5, 32'd1000, 32'd7);
            repeat (10) tick();
            if (k == 0) flush = 1'b1;
            else rst = 1'b1;
            tick();
            flush = 1'b0;
            rst = 1'b0;
            chk("kill_in_ready", in_ready, 1'b1);
            chk("kill_busy", busy, 1'b0);
            chk("kill_result", result, 32'h0);
            seen = 0;
            for (int i = 0; i < 40; i++) begin
                tick();
                if (out_valid) seen++;
            end
            chk("kill_no_valid", seen, 0);
            run(3'd3, ONES, ONES, 32'hFFFF_FFFE, "after_kill_mulhu");
        end

        for (int i = 0; i < 80; i++) begin
            o = 3'($urandom_range(0, 7));
            x = pick();
            y = pick();
            issue(o, x, y);
            if ($urandom_range(0, 9) == 0) begin
                repeat ($urandom_range(0, 40)) tick();
                flush = 1'b1;
                tick();
                flush = 1'b0;
            end else begin
                wait_valid(is_special(o, x, y) ? 0 : XLEN + 1, "rand");
                chk("rand_result", result, model(o, x, y));
                repeat ($urandom_range(0, 3)) tick();
                take();
            end
        end

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
